rr_arbiter32: RTL and testbench

RR_ARBITER32 -- requirements
Module: rr_arbiter32

---
 rtl/rr_arbiter32_pkg.sv | 13 +
 rtl/rr_arbiter32_if.sv | 30 +++
 rtl/decoder5_32.sv | 9 +
 rtl/rr_arbiter32.sv | 90 +++++++++
 tb/tb_rr_arbiter32.sv | 135 +++++++++++++
 5 files changed

// File: rtl/rr_arbiter32_pkg.sv
// rtl/rr_arbiter32_pkg.sv - shared sizes and state encoding for the round-robin arbiter
package rr_arbiter32_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter32_if.sv
// rtl/rr_arbiter32_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter32_if;
    import rr_arbiter32_pkg::*;

    logic [N_REQ-1:0] req;
    logic             release_req;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_onehot;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req,
        output release_req,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  hold_cnt
    );

    modport slave (
        input  req,
        input  release_req,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output hold_cnt
    );

endinterface

// File: rtl/decoder5_32.sv
// rtl/decoder5_32.sv - 5-to-32 one-hot decoder
module decoder5_32 (
    input  logic [4:0]  idx,
    output logic [31:0] onehot
);

    assign onehot = 32'd1 << idx;

endmodule

// File: rtl/rr_arbiter32.sv
// rtl/rr_arbiter32.sv - 32-way round-robin arbiter with bounded grant hold time
module rr_arbiter32
    import rr_arbiter32_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter32_if.slave    bus
);

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] pick;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] decoded;
    logic             leave;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Requests at or above ptr win; otherwise wrap to the lowest set bit overall.
    assign masked = bus.req & ({N_REQ{1'b1}} << ptr);
    assign pick   = (masked != '0) ? lowest_set(masked) : lowest_set(bus.req);
    assign leave  = bus.release_req || !bus.req[idx] || (cnt == CNT_W'(HOLD_MAX));

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        idx_next   = idx;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    state_next = GRANT;
                    idx_next   = pick;
                    cnt_next   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (leave) begin
                    state_next = IDLE;
                    ptr_next   = idx + IDX_W'(1);
                    idx_next   = '0;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    decoder5_32 u_decoder (
        .idx    (idx),
        .onehot (decoded)
    );

    assign bus.grant_valid  = (state == GRANT);
    assign bus.grant_idx    = idx;
    assign bus.grant_onehot = decoded & {N_REQ{state == GRANT}};
    assign bus.hold_cnt     = cnt;

endmodule

// File: tb/tb_rr_arbiter32.sv
// tb/tb_rr_arbiter32.sv - scoreboard bench for rr_arbiter32
module tb_rr_arbiter32;

    typedef struct {
        logic        valid;
        logic [4:0]  idx;
        logic [7:0]  cnt;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   total;
    int   bad;

    rr_arbiter32_if bus ();

    rr_arbiter32 #(.HOLD_MAX(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every expectation pushed at a rising edge is compared at the following falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [31:0] oh;
            e  = sb.pop_front();
            oh = e.valid ? (32'd1 << e.idx) : 32'd0;
            check({e.tag, ".valid"},  {31'd0, bus.grant_valid}, {31'd0, e.valid});
            check({e.tag, ".idx"},    {27'd0, bus.grant_idx},   {27'd0, e.idx});
            check({e.tag, ".onehot"}, bus.grant_onehot,         oh);
            check({e.tag, ".cnt"},    {24'd0, bus.hold_cnt},    {24'd0, e.cnt});
        end
    end

    task automatic step(input logic rs, input logic [31:0] r, input logic rl,
                        input logic ev, input logic [4:0] ei, input logic [7:0] ec,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst_n           = rs;
        bus.req         = r;
        bus.release_req = rl;
        @(posedge clk);
        e.valid = ev;
        e.idx   = ei;
        e.cnt   = ec;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        bus.req         = '0;
        bus.release_req = 1'b0;

        step(0, 32'h0, 0, 0, 0, 0, "reset0");
        step(0, 32'h5, 0, 0, 0, 0, "reset1");

        // Scenario 1: req 0x5 alternates 0,2,0 with idle cycles between grants
        step(1, 32'h5, 0, 1, 0, 1, "s1_g0a");
        step(1, 32'h5, 0, 1, 0, 2, "s1_g0b");
        step(1, 32'h5, 1, 0, 0, 0, "s1_idle1");
        step(1, 32'h5, 0, 1, 2, 1, "s1_g2");
        step(1, 32'h5, 1, 0, 0, 0, "s1_idle2");
        step(1, 32'h5, 0, 1, 0, 1, "s1_g0c");
        step(1, 32'h5, 1, 0, 0, 0, "s1_idle3");
        step(1, 32'h0, 0, 0, 0, 0, "s1_noreq");

        // Scenario 2: grant 30 leaves ptr=31, req 0x3 wraps to 0, ptr then 1
        step(1, 32'h4000_0000, 0, 1, 30, 1, "s2_g30");
        step(1, 32'h4000_0000, 1, 0, 0, 0, "s2_idle1");
        step(1, 32'h3, 0, 1, 0, 1, "s2_wrap0");
        step(1, 32'h3, 1, 0, 0, 0, "s2_idle2");
        step(1, 32'h3, 0, 1, 1, 1, "s2_g1");
        step(1, 32'h3, 1, 0, 0, 0, "s2_idle3");

        // Scenario 4: owner 7 drops its request on grant cycle 3; ptr=8 picks 9 over 7
        step(1, 32'h280, 0, 1, 7, 1, "s4_g7a");
        step(1, 32'h281, 0, 1, 7, 2, "s4_g7b");
        step(1, 32'h280, 0, 1, 7, 3, "s4_g7c");
        step(1, 32'h200, 0, 0, 0, 0, "s4_drop");
        step(1, 32'h280, 0, 1, 9, 1, "s4_g9");
        step(1, 32'h280, 1, 0, 0, 0, "s4_idle");

        // Scenario 6: release with expiry gives one ptr step (10 -> 11, not 12)
        step(1, 32'hC00, 0, 1, 10, 1, "s6_g10");
        for (int c = 2; c <= 16; c++) step(1, 32'hC00, 0, 1, 10, 8'(c), "s6_hold");
        step(1, 32'hC00, 1, 0, 0, 0, "s6_idle");
        step(1, 32'hC00, 0, 1, 11, 1, "s6_g11");
        step(1, 32'hC00, 1, 0, 0, 0, "s6_idle2");

        // Scenario 5: reset during grant 12 clears everything; search restarts at 0
        step(1, 32'h1001, 0, 1, 12, 1, "s5_g12a");
        step(1, 32'h1001, 0, 1, 12, 2, "s5_g12b");
        step(0, 32'h1001, 0, 0, 0, 0, "s5_reset");
        step(1, 32'h1001, 0, 1, 0, 1, "s5_g0");
        step(1, 32'h1001, 1, 0, 0, 0, "s5_idle");

        // Scenario 3: all requesting, no release -> 16-cycle grants rotating 0..31,0
        step(0, 32'h0, 0, 0, 0, 0, "s3_reset");
        for (int k = 0; k <= 32; k++) begin
            for (int c = 1; c <= 16; c++)
                step(1, 32'hFFFF_FFFF, 0, 1, 5'(k % 32), 8'(c), "s3_hold");
            step(1, 32'hFFFF_FFFF, 0, 0, 0, 0, "s3_idle");
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
